// File: rtl/cbus_sram_responder.sv
// cbus_sram_responder
//   Memory-side cbus responder backed by a word-addressed on-chip SRAM.
//   It accepts one burst request at a time and answers with one beat per
//   unstalled BURST cycle. Bursts wrap inside their N-aligned block, so
//   the critical word comes first. Writes are byte-strobed. The first beat
//   follows FIRST_DELAY idle cycles after acceptance.
//
// Parameters
//   MEM_WORDS   SRAM depth in 32-bit words (power of two, 16 .. 2^29)
//   FIRST_DELAY idle cycles between acceptance and the first beat (0..15)
//   BASE_ADDR   byte address that maps to word 0
//
// Ports
//   clk     clock
//   resetn  synchronous active-low reset
//   creq    request: valid, is_write, size, addr, strobe, data, len
//   cresp   response: ready, last, data
//   stall   throttle; suppresses the beat of any BURST cycle in which it is high
//   busy    high whenever the responder is not idle

package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;     // beat count minus one
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_sram_responder
    import cbus_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 4096,
    parameter int unsigned FIRST_DELAY = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp,
    input  logic       stall,
    output logic       busy
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_e;

    state_e        state_q, state_d;
    logic [3:0]    delay_q, delay_d;
    logic [3:0]    beat_q, beat_d;
    logic [3:0]    len_q, len_d;
    logic          is_write_q, is_write_d;
    logic [AW-1:0] ptr_q, ptr_d;      // SRAM word used by the current beat
    logic [31:0]   data_q, data_d;    // prefetched read word for the current beat

    logic [31:0]   mem [MEM_WORDS];

    logic [31:0]   req_offset;
    logic [AW-1:0] req_word;
    logic [3:0]    wrap_mask;
    logic [AW-1:0] wrap_mask_w;
    logic [AW-1:0] ptr_next;
    logic          mem_we;
    logic          unused_ok;

    // Bits above the SRAM index and the byte offset are ignored.
    assign req_offset = creq.addr - BASE_ADDR;
    assign req_word   = req_offset[AW+1:2];
    assign unused_ok  = ^{creq.size, req_offset[31:AW+2], req_offset[1:0]};

    // Smear len into an all-ones mask. For the power-of-two beat counts this
    // is N-1. For other counts the burst wraps inside the enclosing
    // power-of-two block.
    assign wrap_mask   = len_q | (len_q >> 1) | (len_q >> 2) | (len_q >> 3);
    assign wrap_mask_w = AW'(wrap_mask);
    assign ptr_next    = (ptr_q & ~wrap_mask_w) | ((ptr_q + AW'(1)) & wrap_mask_w);

    // NOTE: every signal of a combinational block gets a default before the
    // case statement, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        beat_d     = beat_q;
        len_d      = len_q;
        is_write_d = is_write_q;
        ptr_d      = ptr_q;
        data_d     = data_q;
        mem_we     = 1'b0;
        cresp      = '0;
        busy       = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (creq.valid) begin
                    is_write_d = creq.is_write;
                    len_d      = creq.len;
                    ptr_d      = req_word;
                    beat_d     = 4'd0;
                    delay_d    = 4'(FIRST_DELAY);
                    if (FIRST_DELAY == 0) begin
                        // No wait phase, so fetch the first word now.
                        state_d = S_BURST;
                        data_d  = mem[req_word];
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!creq.valid) begin
                    state_d = S_IDLE;
                end else begin
                    delay_d = delay_q - 4'd1;
                    if (delay_q == 4'd1) begin
                        state_d = S_BURST;
                        data_d  = mem[ptr_q];
                    end
                end
            end
            S_BURST: begin
                if (!creq.valid) begin
                    state_d = S_IDLE;
                end else if (!stall) begin
                    cresp.ready = 1'b1;
                    cresp.last  = (beat_q == len_q);
                    // The reset edge must not commit a beat of an aborted burst.
                    mem_we      = is_write_q && resetn;
                    beat_d      = beat_q + 4'd1;
                    ptr_d       = ptr_next;
                    data_d      = mem[ptr_next];
                    if (beat_q == len_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_BURST && !is_write_q) begin
            cresp.data = data_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then update together at the edge, whatever order the blocks run in.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            delay_q    <= 4'd0;
            beat_q     <= 4'd0;
            len_q      <= 4'd0;
            is_write_q <= 1'b0;
            ptr_q      <= '0;
            data_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            is_write_q <= is_write_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
        end
    end

    // NOTE: the SRAM array has no reset. Its contents survive resetn, and an
    // unreset array can map onto a real RAM macro with byte enables.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (creq.strobe[i]) begin
                    mem[ptr_q][8*i +: 8] <= creq.data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cbus_sram_responder.sv
module tb_cbus_sram_responder;
    import cbus_pkg::*;

    localparam int MW         = 1024;
    localparam int TXN_LIMIT  = 400;
    localparam int LENS [5]   = '{0, 1, 3, 7, 15};

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    cbus_req_t  creq  [2];
    cbus_resp_t cresp [2];
    logic       stall [2];
    logic       busy  [2];

    always #5 clk = ~clk;

    // Unit 0: FIRST_DELAY=2 at base 0. Unit 1: FIRST_DELAY=0 at a high base.
    cbus_sram_responder #(.MEM_WORDS(MW), .FIRST_DELAY(2), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .resetn(resetn), .creq(creq[0]), .cresp(cresp[0]), .stall(stall[0]), .busy(busy[0]));
    cbus_sram_responder #(.MEM_WORDS(MW), .FIRST_DELAY(0), .BASE_ADDR(32'h8000_0000)) dut1 (
        .clk(clk), .resetn(resetn), .creq(creq[1]), .cresp(cresp[1]), .stall(stall[1]), .busy(busy[1]));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] base_of(input int u);
        return (u == 1) ? 32'h8000_0000 : 32'h0000_0000;
    endfunction

    function automatic int delay_of(input int u);
        return (u == 1) ? 0 : 2;
    endfunction

    // Word of beat k: wrap inside the n-aligned block that holds w0.
    function automatic int word_of(input int w0, input int n, input int k);
        return (w0 / n) * n + ((w0 % n) + k) % n;
    endfunction

    // ---------------- behavioural model ----------------
    bit          chk_en = 1'b0;
    bit          m_act  [2];
    int          m_wait [2];
    int          m_beat [2];
    int          m_n    [2];
    int          m_w0   [2];
    bit          m_wr   [2];
    int          viol   [2];
    logic [31:0] mem_m  [2][MW];
    bit          known  [2][MW];

    always @(negedge clk) begin : compare
        bit e_rdy;
        bit e_last;
        int idx;
        for (int u = 0; u < 2; u++) begin
            e_rdy  = m_act[u] && m_wait[u] == 0 && creq[u].valid && !stall[u];
            e_last = e_rdy && (m_beat[u] == m_n[u] - 1);
            idx    = word_of(m_w0[u], (m_n[u] > 0) ? m_n[u] : 1, m_beat[u]);
            if (chk_en) begin
                check_bit($sformatf("u%0d busy", u), busy[u], m_act[u]);
                check_bit($sformatf("u%0d ready", u), cresp[u].ready, e_rdy);
                check_bit($sformatf("u%0d last", u), cresp[u].last, e_last);
                if (e_rdy) begin
                    if (m_wr[u])
                        check($sformatf("u%0d write beat data", u), cresp[u].data, 32'h0);
                    else if (known[u][idx])
                        check($sformatf("u%0d read beat %0d word %0h", u, m_beat[u], idx),
                              cresp[u].data, mem_m[u][idx]);
                end
            end
            // Advance to the state after the coming clock edge.
            if (!resetn) begin
                m_act[u] = 1'b0;
            end else if (!m_act[u]) begin
                if (creq[u].valid) begin
                    m_act[u]  = 1'b1;
                    m_wait[u] = delay_of(u);
                    m_beat[u] = 0;
                    m_n[u]    = int'(creq[u].len) + 1;
                    m_wr[u]   = creq[u].is_write;
                    m_w0[u]   = int'(((creq[u].addr - base_of(u)) >> 2) % MW);
                end
            end else if (!creq[u].valid) begin
                m_act[u] = 1'b0;
                viol[u]++;
            end else if (m_wait[u] > 0) begin
                m_wait[u]--;
            end else if (e_rdy) begin
                if (m_wr[u]) begin
                    for (int i = 0; i < 4; i++)
                        if (creq[u].strobe[i]) mem_m[u][idx][8*i +: 8] = creq[u].data[8*i +: 8];
                    if (creq[u].strobe == 4'hF) known[u][idx] = 1'b1;
                end
                m_beat[u]++;
                if (m_beat[u] == m_n[u]) m_act[u] = 1'b0;
            end
        end
    end

    // ---------------- initiator ----------------
    logic [31:0] wdata [16];
    logic [3:0]  wstrb [16];
    logic [31:0] rd_data [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd_at(input int k);
        return (rd_data.size() > k) ? rd_data[k] : 32'hDEAD_DEAD;
    endfunction

    // Presents one burst and holds it until last. smode: 0 no stall,
    // 1 random stall, 2 three stall cycles before beats 2 and 5.
    // rst_after >= 0 pulses resetn after that many beats.
    task automatic run_txn(input int u, input bit wr, input logic [31:0] addr, input int len,
                           input int smode, input int rst_after,
                           output int first_rdy, output int nrdy, output int burst_cyc);
        int       b   = 0;
        int       st  = 0;
        int       cyc = 0;
        bit       done = 1'b0;
        bit       stl;
        logic [2:0] sz;
        sz = 3'($urandom_range(7));
        first_rdy = -1;
        nrdy      = 0;
        burst_cyc = 0;
        rd_data.delete();
        while (!done && cyc < TXN_LIMIT) begin
            creq[u].valid    = 1'b1;
            creq[u].is_write = wr;
            creq[u].size     = sz;
            creq[u].addr     = addr;
            creq[u].len      = 4'(len);
            creq[u].data     = wdata[(b > 15) ? 15 : b];
            creq[u].strobe   = wstrb[(b > 15) ? 15 : b];
            stl = 1'b0;
            if (smode == 1) stl = ($urandom_range(3) == 0);
            else if (smode == 2) stl = ((b == 2) || (b == 5)) && (st < 3);
            if (stl) st++;
            stall[u] = stl;
            @(negedge clk);
            if (first_rdy >= 0 || cresp[u].ready) burst_cyc++;
            if (cresp[u].ready) begin
                if (first_rdy < 0) first_rdy = cyc;
                if (!wr) rd_data.push_back(cresp[u].data);
                nrdy++;
                b++;
                st = 0;
                if (cresp[u].last) done = 1'b1;
            end
            tick();
            cyc++;
            if (!done && rst_after >= 0 && b == rst_after) begin
                resetn   = 1'b0;
                stall[u] = 1'b1;
                @(negedge clk);
                tick();
                resetn        = 1'b1;
                creq[u].valid = 1'b0;
                stall[u]      = 1'b0;
                @(negedge clk);
                check_bit($sformatf("u%0d ready after reset edge", u), cresp[u].ready, 1'b0);
                check_bit($sformatf("u%0d busy after reset edge", u), busy[u], 1'b0);
                tick();
                done = 1'b1;
            end
        end
        creq[u].valid = 1'b0;
        stall[u]      = 1'b0;
        check_bit($sformatf("u%0d txn completed", u), done, 1'b1);
    endtask

    task automatic preload(input int u, input int word, input int blocks, input logic [31:0] pat);
        int fr, nr, bc;
        for (int blk = 0; blk < blocks; blk++) begin
            for (int k = 0; k < 16; k++) begin
                wdata[k] = pat + 32'(word + blk * 16 + k);
                wstrb[k] = 4'hF;
            end
            run_txn(u, 1'b1, base_of(u) + 32'((word + blk * 16) * 4), 15, 0, -1, fr, nr, bc);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fr, nr, bc, v0;
        for (int u = 0; u < 2; u++) begin
            creq[u]  = '0;
            stall[u] = 1'b0;
        end
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check_bit($sformatf("u%0d reset busy", u), busy[u], 1'b0);
            check_bit($sformatf("u%0d reset ready", u), cresp[u].ready, 1'b0);
            check_bit($sformatf("u%0d reset last", u), cresp[u].last, 1'b0);
            check($sformatf("u%0d reset data", u), cresp[u].data, 32'h0);
        end
        tick();

        // Preload known contents.
        preload(0, 0, 4, 32'hA000_0000);
        preload(0, 32'h80, 1, 32'hC000_0000);
        preload(1, 0, 4, 32'hB000_0000);

        // Aligned 16-beat read with FIRST_DELAY=2.
        run_txn(0, 1'b0, 32'h40, 15, 0, -1, fr, nr, bc);
        check("read first ready cycle", 32'(fr), 32'd3);
        check("read beat count", 32'(nr), 32'd16);
        check("read beat 0", rd_at(0), 32'hA000_0010);
        check("read beat 15", rd_at(15), 32'hA000_001F);
        @(negedge clk);
        check_bit("busy cycle after last", busy[0], 1'b0);
        tick();

        // Critical-word-first wrap.
        run_txn(0, 1'b0, 32'h74, 15, 0, -1, fr, nr, bc);
        check("wrap beat count", 32'(nr), 32'd16);
        check("wrap beat 0", rd_at(0), 32'hA000_001D);
        check("wrap beat 2", rd_at(2), 32'hA000_001F);
        check("wrap beat 3", rd_at(3), 32'hA000_0010);
        check("wrap beat 15", rd_at(15), 32'hA000_001C);

        // Strobed write over an all-ones block.
        for (int k = 0; k < 16; k++) begin
            wdata[k] = 32'hFFFF_FFFF;
            wstrb[k] = 4'hF;
        end
        run_txn(0, 1'b1, 32'h100, 3, 0, -1, fr, nr, bc);
        wdata[0] = 32'h1111_1111; wstrb[0] = 4'b1111;
        wdata[1] = 32'h2222_2222; wstrb[1] = 4'b0011;
        wdata[2] = 32'h3333_3333; wstrb[2] = 4'b1100;
        wdata[3] = 32'h4444_4444; wstrb[3] = 4'b0000;
        run_txn(0, 1'b1, 32'h100, 3, 0, -1, fr, nr, bc);
        check("model strobe word 1", mem_m[0][65], 32'hFFFF_2222);
        run_txn(0, 1'b0, 32'h100, 3, 0, -1, fr, nr, bc);
        check("strobe readback 0", rd_at(0), 32'h1111_1111);
        check("strobe readback 1", rd_at(1), 32'hFFFF_2222);
        check("strobe readback 2", rd_at(2), 32'h3333_FFFF);
        check("strobe readback 3", rd_at(3), 32'hFFFF_FFFF);

        // Stall injection: two 3-cycle stalls inside an 8-beat read.
        run_txn(0, 1'b0, 32'h20, 7, 2, -1, fr, nr, bc);
        check("stall burst cycles", 32'(bc), 32'd14);
        check("stall beat count", 32'(nr), 32'd8);
        for (int k = 0; k < 8; k++)
            check($sformatf("stall beat %0d", k), rd_at(k), 32'hA000_0008 + 32'(k));

        // Single beats back to back with FIRST_DELAY=0.
        run_txn(1, 1'b0, 32'h8000_0014, 0, 0, -1, fr, nr, bc);
        check("single first ready cycle", 32'(fr), 32'd1);
        check("single data", rd_at(0), 32'hB000_0005);
        run_txn(1, 1'b0, 32'h8000_0018, 0, 0, -1, fr, nr, bc);
        check("back-to-back first ready cycle", 32'(fr), 32'd1);
        check("back-to-back data", rd_at(0), 32'hB000_0006);

        // Reset after beat 5 of a 16-beat write, then a fresh read.
        for (int k = 0; k < 16; k++) begin
            wdata[k] = 32'hD000_0000 + 32'(k);
            wstrb[k] = 4'hF;
        end
        run_txn(0, 1'b1, 32'h200, 15, 0, 5, fr, nr, bc);
        check("beats before reset", 32'(nr), 32'd5);
        run_txn(0, 1'b0, 32'h200, 15, 0, -1, fr, nr, bc);
        check("post-reset beat count", 32'(nr), 32'd16);
        check("post-reset word 0", rd_at(0), 32'hD000_0000);
        check("post-reset word 4", rd_at(4), 32'hD000_0004);
        check("post-reset word 5", rd_at(5), 32'hC000_0085);
        check("post-reset word 15", rd_at(15), 32'hC000_008F);
        check("unit 1 memory kept over reset", mem_m[1][7], 32'hB000_0007);

        // Initiator drops valid during WAIT: responder must go idle.
        v0 = viol[0];
        creq[0]       = '0;
        creq[0].valid = 1'b1;
        creq[0].len   = 4'd3;
        tick();
        creq[0].valid = 1'b0;
        tick();
        @(negedge clk);
        check_bit("busy after valid drop", busy[0], 1'b0);
        tick();
        check("protocol violation flagged", 32'(viol[0] - v0), 32'd1);

        // Random traffic against the model.
        for (int t = 0; t < 80; t++) begin
            int          u;
            int          len;
            int          w;
            bit          wr;
            logic [31:0] a;
            u   = int'($urandom_range(1));
            wr  = 1'($urandom_range(1));
            len = LENS[$urandom_range(4)];
            w   = int'($urandom_range(63));
            a   = base_of(u) + 32'(w * 4) + 32'($urandom_range(3));
            for (int k = 0; k < 16; k++) begin
                wdata[k] = $urandom;
                wstrb[k] = 4'($urandom_range(15));
            end
            run_txn(u, wr, a, len, 1, -1, fr, nr, bc);
            check($sformatf("random txn %0d beats", t), 32'(nr), 32'(len + 1));
            repeat ($urandom_range(2)) tick();
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbus_sram_responder.md
Name: cbus_sram_responder

Overview:
- Memory-side responder for the cache bus (cbus): accepts cbus_req_t bursts from an initiator (ICache/DCache refill, writeback, uncached access) and answers with cbus_resp_t beats from an on-chip word-addressed SRAM.
- Used as refill memory in the standalone cache benches and as the boot/scratch SRAM behind the cbus arbiter.
- Supports wrapping bursts (critical-word-first), byte-strobed writes, programmable first-beat latency and externally injected beat stalls.

Parameters:
- MEM_WORDS, 4096, SRAM depth in 32-bit words; power of two.
- FIRST_DELAY, 2, idle cycles between request acceptance and the first data beat; range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; address bits above log2(MEM_WORDS)+2 are ignored.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- creq  in  cbus_req_t  request: valid, is_write, size, addr, strobe, data, len.
- cresp  out  cbus_resp_t  response: ready, last, data.
- stall  in  1  bench/arbiter throttle; when high in BURST, no beat is issued that cycle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (resetn=0 at posedge):
  - state<=IDLE; beat counter, delay counter and data register cleared.
  - cresp.ready=0, cresp.last=0, cresp.data=0, busy=0.
  - SRAM contents are not cleared.
  - Reset mid-burst aborts the burst with no further beats; partially written words keep the values already written.
- Protocol:
  - The initiator holds creq.valid and all request fields stable until the cycle after last.
  - For writes, the initiator presents the next beat's data/strobe in the cycle after each ready.
- Beat count N = len+1 (MLEN1=0 ... MLEN16=15 gives 1..16 beats). size does not change the beat count; reads always return the full word.
- Addressing:
  - Start word w0 = (addr-BASE_ADDR)>>2, taken mod MEM_WORDS.
  - Beat k uses word {w0[high:log2 N], (w0[log2 N-1:0]+k) mod N}, i.e. wrapping within the N-aligned block.
  - Example: N=16, w0 offset 13 gives beats 13,14,15,0,1,...,12.
- FSM:
  - IDLE: if creq.valid, latch is_write, len, w0; delay counter<=FIRST_DELAY; go to WAIT (or directly to BURST when FIRST_DELAY=0). busy asserts the next cycle.
  - WAIT: decrement the delay counter; on reaching 0 go to BURST. For reads, the first word is fetched during the last WAIT cycle.
  - BURST, each cycle with stall=0:
    - ready=1.
    - Read: cresp.data = registered word for the current beat (valid in the same cycle as ready); the next word is fetched concurrently.
    - Write: SRAM word written with creq.data under creq.strobe (byte i enabled by strobe[i]); cresp.data=0.
    - The beat counter increments; last=1 on beat N-1; then go to IDLE.
  - BURST with stall=1: ready=0, last=0, counter and data hold, no SRAM write.
- A new request is accepted at the earliest in the IDLE cycle after last. There is no pipelining of requests.
- If creq.valid falls while in WAIT or BURST (protocol violation): return to IDLE next cycle, no further beats. The bench must flag this as an error.
- stall is ignored in IDLE and WAIT. It does not extend FIRST_DELAY.
- ready/last are never asserted outside BURST. last is never asserted without ready.

Test Plan:
- Read burst: preload word i = 32'hA000_0000+i; read addr=0x40, MLEN16, FIRST_DELAY=2 -> ready first at cycle 3 after valid; data A000_0010..A000_001F; last only on 16th beat; busy drops the cycle after last.
- Wrapped refill: read addr=0x74 (offset 13), MLEN16 -> beat order words 0x1D,0x1E,0x1F,0x10,...,0x1C; exactly 16 readies.
- Strobed write: write addr=0x100, MLEN4, data 11111111/22222222/33333333/44444444, strobe 4'b1111,4'b0011,4'b1100,4'b0000 over preload FFFFFFFF -> readback 11111111, FFFF2222, 3333FFFF, FFFFFFFF.
- Stall injection: read MLEN8 with stall high on beats 2 and 5 for 3 cycles each -> 14 BURST cycles; 8 readies with correct in-order data; no ready/last during stall.
- Single beat with FIRST_DELAY=0: read MLEN1 -> ready and last together in the cycle after valid is sampled; the next request is accepted in the following cycle.
- Reset mid-burst: assert resetn=0 after beat 5 of a 16-beat write -> ready=0 and busy=0 after the reset edge; words 0..4 written, 5..15 unchanged; a fresh read after reset completes normally.
